// File: rtl/mem_write_monitor.sv
// Write-bus monitor: matches stores against NCHK (addr, data) checkpoints and ends in PASS or FAIL (watchdog).
// Optional store/checkpoint logging via MEM_WRITE_MONITOR_LOG_EN (simulation only).
module mem_write_monitor #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned NCHK    = 4,
   parameter int unsigned CNT_W   = 10,
   parameter int unsigned TIMEOUT = 48
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [1:0]               memwrite,
   input  logic [ADDR_W-1:0]        dataadr,
   input  logic [DATA_W-1:0]        writedata,
   input  logic [NCHK*ADDR_W-1:0]   chk_addr,
   input  logic [NCHK*DATA_W-1:0]   chk_data,
   input  logic [NCHK-1:0]          chk_en,
   input  logic [NCHK-1:0]          chk_final,
   output logic [NCHK-1:0]          hit_mask,
   output logic                     pass,
   output logic                     fail,
   output logic                     done,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [15:0]              wr_count,
   output logic [ADDR_W-1:0]        last_addr,
   output logic [DATA_W-1:0]        last_data
);

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_FAIL = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [NCHK-1:0] match_c;
   logic            wr_c;
   logic            final_hit_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic            timeout_c;

   // Per-entry exact full-width match on the current bus cycle
   for (genvar gi = 0; gi < NCHK; gi++) begin : g_match
      assign match_c[gi] = chk_en[gi] && wr_c
                           && (dataadr   == chk_addr[gi*ADDR_W +: ADDR_W])
                           && (writedata == chk_data[gi*DATA_W +: DATA_W]);
   end

   assign wr_c        = (memwrite != 2'b00);
   assign final_hit_c = |(match_c & chk_final);
   assign cnt_inc_c   = cycle_cnt + CNT_W'(1);
   assign timeout_c   = (cnt_inc_c == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_RUN;
      else        state <= state_nxt;
   end

   // Final hit outranks the watchdog; clear outranks everything
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               if (final_hit_c)    state_nxt = S_PASS;
               else if (timeout_c) state_nxt = S_FAIL;
            end
            S_PASS:  state_nxt = S_PASS;
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_mask  <= '0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         done      <= 1'b0;
         cycle_cnt <= '0;
         wr_count  <= '0;
         last_addr <= '0;
         last_data <= '0;
      end else begin
         pass <= (state_nxt == S_PASS);
         fail <= (state_nxt == S_FAIL);
         done <= (state_nxt != S_RUN);
         if (clear) begin
            hit_mask  <= '0;
            cycle_cnt <= '0;
            wr_count  <= '0;
            last_addr <= '0;
            last_data <= '0;
         end else if (state == S_RUN) begin
            cycle_cnt <= cnt_inc_c;
            hit_mask  <= hit_mask | match_c;
            if (wr_c) begin
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
               last_addr <= dataadr;
               last_data <= writedata;
            end
         end
      end
   end

`ifdef MEM_WRITE_MONITOR_LOG_EN
   // Console trace of run progress; register behaviour is unaffected
   always @(posedge clk) begin
      if (reset && !clear && (state == S_RUN)) begin
         if (wr_c) $display("Write %0d in %0d", writedata, dataadr);
         for (int i = 0; i < int'(NCHK); i++)
            if (match_c[i] && !hit_mask[i]) $display("Checkpoint %0d pass!", i);
         if (state_nxt == S_PASS)      $display("Test pass!");
         else if (state_nxt == S_FAIL) $display("Some error occurs!");
      end
   end
`endif

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Parametrised write-bus monitor for the MIPS core's data-memory port. Observes `memwrite`/`dataadr`/`writedata` every cycle, compares each store against a table of NCHK expected (address, data) checkpoints, tracks which have been hit, and terminates in PASS or FAIL (cycle watchdog). Sits beside `top` in simulation benches and can also be synthesised as an on-chip self-test status block driving LEDs.

## Interface
Parameters:
- `ADDR_W`, 64: data-address width.
- `DATA_W`, 64: write-data width.
- `NCHK`, 4: number of checkpoint entries (1..16).
- `CNT_W`, 10: watchdog counter width.
- `TIMEOUT`, 48: cycle count at which FAIL is declared; must be < 2^CNT_W.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous restart; returns the block to the post-reset state.
- `memwrite` in 2: store strobe; any nonzero value is a write.
- `dataadr` in ADDR_W: store address.
- `writedata` in DATA_W: store data.
- `chk_addr` in NCHK*ADDR_W: flattened checkpoint addresses; entry i is at bits [i*ADDR_W +: ADDR_W].
- `chk_data` in NCHK*DATA_W: flattened checkpoint data.
- `chk_en` in NCHK: entry enable.
- `chk_final` in NCHK: entry is terminating; a hit ends the run in PASS.
- `hit_mask` out NCHK: sticky per-entry hit flags.
- `pass` out 1: run ended in PASS.
- `fail` out 1: run ended in FAIL (timeout).
- `done` out 1: `pass | fail`.
- `cycle_cnt` out CNT_W: cycles elapsed in RUN.
- `wr_count` out 16: stores observed, saturating at 16'hFFFF.
- `last_addr` out ADDR_W, `last_data` out DATA_W: most recent store.

## Operation
- FSM states: RUN, PASS, FAIL. Reset or `clear` enters RUN. PASS and FAIL hold until reset or `clear`.
- Match rule, entry i: `chk_en[i]` & `memwrite != 0` & `dataadr == chk_addr_i` & `writedata == chk_data_i`. Comparison is exact, full width, and combinational on the current inputs.
- Matches while in RUN:
  - Every matching entry sets its `hit_mask` bit. Multiple entries may hit on one store.
  - Any matching entry with `chk_final` set causes RUN to PASS.
  - Non-final hits are recorded and RUN continues.
- Watchdog: in RUN, `cycle_cnt` increments every cycle. On the edge where `cycle_cnt` would become TIMEOUT with no final hit, the FSM goes RUN to FAIL. `cycle_cnt` freezes in PASS and FAIL.
- Priority: a final hit and the timeout on the same cycle resolve to PASS.
- `wr_count`, `last_addr`, `last_data` update on every store while in RUN, and are frozen in PASS and FAIL.
- `clear` has priority over every other event in the same cycle.

## Timing
- All outputs are registered. A store sampled at rising edge k is reflected in `hit_mask`, `pass`, `wr_count`, `last_*` after edge k; latency is 1 cycle.
- `fail` asserts at the edge where `cycle_cnt` reaches TIMEOUT (the TIMEOUT-th edge after reset release).
- Reset values (asynchronous, `reset`=0):
  - state RUN.
  - `hit_mask`=0, `pass`=0, `fail`=0, `done`=0.
  - `cycle_cnt`=0, `wr_count`=0, `last_addr`=0, `last_data`=0.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge. Counting resumes on the first rising edge after release.
- Stores arriving in PASS or FAIL are ignored.

## Configuration
- `MEM_WRITE_MONITOR_LOG_EN` defined:
  - The block `$display`s "Write <data> in <addr>" for every store in RUN.
  - It prints "Checkpoint <i> pass!" per newly hit entry, "Test pass!" on entering PASS, and "Some error occurs!" on entering FAIL.
  - No `$stop` is issued; benches stop on `done`.
- Undefined: no system tasks are present; the block is fully synthesisable. Register behaviour is identical in both builds.

## Test plan
- Single final entry: entry 0 = (128, 7), final. Store 128←7 at cycle 10 -> `hit_mask`=0001, `pass`=1, `done`=1 after that edge; `cycle_cnt` frozen at 10.
- Non-final then final: entry 0 = (100, 7) non-final, entry 1 = (80, 1) final. Store 100←7, then 80←1 -> `hit_mask` 0001 then 0011, `pass`=1 only after the second store.
- Timeout: no matching stores -> `fail`=1 at edge 48, `cycle_cnt`=48. A later matching store leaves `hit_mask`=0 and `pass`=0.
- Simultaneous: final hit on the cycle where `cycle_cnt` would reach 48 -> `pass`=1, `fail`=0.
- Near-miss and disabled entry: store 128←6 -> no hit, `wr_count`=1. Entry with `chk_en`=0 matched exactly -> no hit.
- Reset and clear: reset pulled low mid-run after 3 stores -> all outputs 0 immediately. A one-cycle `clear` in PASS -> RUN, `hit_mask`=0, `wr_count`=0 next edge.
